// File: rtl/lsu_byte_sequencer_pkg.sv
// rtl/lsu_byte_sequencer_pkg.sv - shared funct3, access-size and LSU FSM encodings
package lsu_byte_sequencer_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Unsigned loads have no store counterpart, so they are illegal with we=1.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] size_last_idx(input logic [1:0] size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of an assembled little-endian load word
module lsu_load_extend
    import lsu_byte_sequencer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{word[7]}}, word[7:0]};
            F3_H:    rdata = {{16{word[15]}}, word[15:0]};
            F3_BU:   rdata = {24'd0, word[7:0]};
            F3_HU:   rdata = {16'd0, word[15:0]};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - splits RV32I loads/stores into sequential byte accesses on an 8-bit dmem
module lsu_byte_sequencer
    import lsu_byte_sequencer_pkg::*;
#(
    parameter int DMEM_RD_LAT = 1
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [7:0]  dmem_din,
    input  logic [7:0]  dmem_dout
);

    localparam bit RD_REG = (DMEM_RD_LAT != 0);

    logic [1:0]  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic        dmem_we_q, dmem_we_d;
    logic [7:0]  dmem_din_q, dmem_din_d;
    logic [31:0] ext_rdata;
    logic [1:0]  last_idx;

    assign last_idx = size_last_idx(req_q.funct3[1:0]);

    // Lane capture lives apart from the FSM so ext_rdata can see the final byte without a comb loop.
    always_comb begin
        word_d = word_q;
        if (state_q == ST_IDLE && req_valid) begin
            word_d = '0;
        end
        if (!RD_REG && state_q == ST_ACCESS && !req_q.we) begin
            word_d[8*idx_q +: 8] = dmem_dout;
        end
        if (rd_pend_q) begin
            word_d[8*rd_idx_q +: 8] = dmem_dout;
        end
    end

    lsu_load_extend u_load_extend (
        .word   (word_d),
        .funct3 (req_q.funct3),
        .rdata  (ext_rdata)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        idx_d       = idx_q;
        rd_pend_d   = 1'b0;
        rd_idx_d    = idx_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        dmem_addr_d = dmem_addr_q;
        dmem_we_d   = 1'b0;
        dmem_din_d  = dmem_din_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                    idx_d = 2'd0;
                    if (f3_illegal(req_funct3, req_we)) begin
                        state_d     = ST_DONE;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        rsp_err_d   = 1'b0;
                        dmem_addr_d = req_addr;
                        dmem_we_d   = req_we;
                        dmem_din_d  = req_wdata[7:0];
                    end
                end
            end
            ST_ACCESS: begin
                rd_pend_d = RD_REG && !req_q.we;
                if (idx_q == last_idx) begin
                    if (req_q.we || !RD_REG) begin
                        state_d     = ST_DONE;
                        rsp_rdata_d = req_q.we ? 32'd0 : ext_rdata;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    idx_d       = idx_q + 2'd1;
                    dmem_addr_d = req_q.addr + {30'd0, idx_d};
                    dmem_we_d   = req_q.we;
                    dmem_din_d  = req_q.wdata[8*idx_d +: 8];
                end
            end
            ST_DRAIN: begin
                state_d     = ST_DONE;
                rsp_rdata_d = ext_rdata;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            idx_q       <= 2'd0;
            word_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= 2'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_we_q   <= 1'b0;
            dmem_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_we_q   <= dmem_we_d;
            dmem_din_q  <= dmem_din_d;
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_err   = rsp_valid & rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign stall     = req_valid & ~rsp_valid;
    assign dmem_addr = dmem_addr_q;
    assign dmem_we   = dmem_we_q;
    assign dmem_din  = dmem_din_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - directed vector bench for lsu_byte_sequencer with a registered byte memory
module tb_lsu_byte_sequencer;
    import lsu_byte_sequencer_pkg::*;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [7:0]  dmem_din;
    logic [7:0]  dmem_dout;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem [0:1023];

    lsu_byte_sequencer #(.DMEM_RD_LAT(1)) dut (
        .sysclk     (sysclk),
        .sysreset   (sysreset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .stall      (stall),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_din   (dmem_din),
        .dmem_dout  (dmem_dout)
    );

    always #5 sysclk = ~sysclk;

    // Registered-read byte memory, aliased on the low 10 address bits.
    always @(posedge sysclk) begin
        dmem_dout <= mem[dmem_addr[9:0]];
        if (dmem_we) mem[dmem_addr[9:0]] = dmem_din;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        int          lat;
        int          nw;
        int          nbytes;
        logic [31:0] w;
        lat = -1;
        nw  = 0;
        @(posedge sysclk); #1;
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            if (c == 1) begin
                req_we = ~v.we; req_funct3 = 3'b011; req_addr = ~v.addr; req_wdata = ~v.wdata;
            end
            if (dmem_we === 1'b1) begin
                w = v.wdata >> (8 * nw);
                chk({name, " wr_addr"}, dmem_addr, v.addr + nw);
                chk({name, " wr_din"}, {24'd0, dmem_din}, {24'd0, w[7:0]});
                nw++;
            end
            chk({name, " stall"}, {31'd0, stall}, {31'd0, c != v.exp_lat});
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, lat, v.exp_lat);
        chk({name, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk({name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({name, " n_writes"}, nw, (v.we && !v.exp_err) ? v.exp_lat - 1 : 0);
        if (!v.exp_err) begin
            nbytes = v.we ? v.exp_lat - 1 : v.exp_lat - 2;
            chk({name, " addr_hold"}, dmem_addr, v.addr + nbytes - 1);
        end
        @(posedge sysclk); #1;
        req_valid = 1'b0;
        @(negedge sysclk);
        chk({name, " rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, " rdata_held"}, rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        vecs[0]  = mk(1'b1, F3_W,   32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5);
        vecs[1]  = mk(1'b0, F3_W,   32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 6);
        vecs[2]  = mk(1'b0, F3_B,   32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 1'b0, 3);
        vecs[3]  = mk(1'b0, F3_BU,  32'h0000_0103, 32'h0,         32'h0000_00DE, 1'b0, 3);
        vecs[4]  = mk(1'b0, F3_H,   32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 1'b0, 4);
        vecs[5]  = mk(1'b0, F3_HU,  32'h0000_0101, 32'h0,         32'h0000_ADBE, 1'b0, 4);
        vecs[6]  = mk(1'b1, F3_B,   32'h0000_0101, 32'h1234_5677, 32'h0000_0000, 1'b0, 2);
        vecs[7]  = mk(1'b0, F3_W,   32'h0000_0100, 32'h0,         32'hDEAD_77EF, 1'b0, 6);
        vecs[8]  = mk(1'b1, F3_W,   32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 5);
        vecs[9]  = mk(1'b0, F3_W,   32'hFFFF_FFFE, 32'h0,         32'hA1B2_C3D4, 1'b0, 6);
        vecs[10] = mk(1'b0, F3_H,   32'hFFFF_FFFF, 32'h0,         32'hFFFF_B2C3, 1'b0, 4);
        vecs[11] = mk(1'b0, F3_W,   32'h0000_0000, 32'h0,         32'h0000_A1B2, 1'b0, 6);
        vecs[12] = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 1);
        vecs[13] = mk(1'b1, F3_BU,  32'h0000_0100, 32'h5555_5555, 32'h0000_0000, 1'b1, 1);
        vecs[14] = mk(1'b1, 3'b111, 32'h0000_0100, 32'h5555_5555, 32'h0000_0000, 1'b1, 1);
        vecs[15] = mk(1'b1, F3_H,   32'h0000_0200, 32'hCAFE_8001, 32'h0000_0000, 1'b0, 3);
        vecs[16] = mk(1'b0, F3_H,   32'h0000_0200, 32'h0,         32'hFFFF_8001, 1'b0, 4);
        vecs[17] = mk(1'b0, F3_HU,  32'h0000_0200, 32'h0,         32'h0000_8001, 1'b0, 4);
        vecs[18] = mk(1'b0, F3_B,   32'h0000_0201, 32'h0,         32'hFFFF_FF80, 1'b0, 3);
        vecs[19] = mk(1'b0, F3_W,   32'h0000_0200, 32'h0,         32'h0000_8001, 1'b0, 6);
        vecs[20] = mk(1'b0, 3'b110, 32'h0000_0200, 32'h0,         32'h0000_0000, 1'b1, 1);

        sysreset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("reset dmem_addr", dmem_addr, 32'd0);
        chk("reset dmem_din", {24'd0, dmem_din}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        @(posedge sysclk); #1;
        sysreset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a word store.
        run_op(mk(1'b1, F3_W, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0, 1'b0, 5), "prefill");
        @(posedge sysclk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h300; req_wdata = 32'h1122_3344;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        chk("rst_mid byte0 we", {31'd0, dmem_we}, 32'd1);
        chk("rst_mid byte0 din", {24'd0, dmem_din}, 32'h44);
        @(posedge sysclk); #1;
        sysreset = 1'b1;
        @(negedge sysclk);
        chk("rst_mid byte1 addr", dmem_addr, 32'h301);
        @(posedge sysclk); #1;
        sysreset = 1'b0; req_valid = 1'b0;
        @(negedge sysclk);
        chk("rst_mid dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid dmem_addr", dmem_addr, 32'd0);
        busy = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sysclk);
            if (dmem_we !== 1'b0 || rsp_valid !== 1'b0) busy++;
        end
        chk("rst_mid quiet", busy, 0);
        chk("rst_mid mem300", {24'd0, mem[10'h300]}, 32'h44);
        chk("rst_mid mem302", {24'd0, mem[10'h302]}, 32'hA5);
        chk("rst_mid mem303", {24'd0, mem[10'h303]}, 32'hA5);
        run_op(mk(1'b0, F3_W, 32'h0000_0300, 32'h0, 32'hA5A5_3344, 1'b0, 6), "post_rst_lw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
